// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the two-source UART transmit arbiter.
// Requester 0 is the JTAG bridge, requester 1 the console.
package uart_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        LOAD,
        WAIT_BUSY,
        WAIT_DONE
    } arb_state_t;

    localparam logic [7:0] EOM_DEFAULT = 8'h0A;
    localparam int         NUM_REQ     = 2;
    localparam int         REQ_JTAG    = 0;
    localparam int         REQ_CON     = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone request wins outright, and on a tie the
// requester that was not served last wins. Purely combinational, one-hot grant.
module rr_arb2
    import uart_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               last_served,
    output logic [NUM_REQ-1:0] gnt
);

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_gnt
            assign gnt[gi] = req[gi] & (~req[1-gi] | (last_served != 1'(gi)));
        end
    endgenerate

endmodule

// File: rtl/uart_tx_arbiter.sv
// Grants one serializer to one of two byte sources for a whole message, which ends
// on EOM_BYTE, after MAX_BURST bytes, or when the owner stays silent for IDLE_TO cycles.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int         MAX_BURST = 16,
    parameter logic [7:0] EOM_BYTE  = EOM_DEFAULT,
    parameter int         IDLE_TO   = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ-1:0][7:0] req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_REQ-1:0]      grant,
    output logic [7:0]              tx_data,
    output logic                    tx_start,
    input  logic                    tx_empty
);

    localparam int                IDLE_W    = $clog2(IDLE_TO + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TO - 1);
    localparam logic [7:0]        BURST_MAX = 8'(MAX_BURST);

    arb_state_t          state_reg, state_next;
    logic [NUM_REQ-1:0]  grant_reg, grant_next;
    logic [7:0]          tx_data_reg, tx_data_next;
    logic [7:0]          burst_reg, burst_next;
    logic [IDLE_W-1:0]   idle_reg, idle_next;
    logic                wb_reg, wb_next;
    logic                last_reg, last_next;

    logic [NUM_REQ-1:0]  rr_gnt;
    logic                owner_idx;
    logic                owner_valid;

    assign owner_idx   = grant_reg[REQ_CON];
    assign owner_valid = req_valid[owner_idx];

    rr_arb2 u_rr_arb2 (
        .req         (req_valid),
        .last_served (last_reg),
        .gnt         (rr_gnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            grant_reg   <= '0;
            tx_data_reg <= '0;
            burst_reg   <= '0;
            idle_reg    <= '0;
            wb_reg      <= 1'b0;
            last_reg    <= 1'(REQ_CON);
        end else begin
            state_reg   <= state_next;
            grant_reg   <= grant_next;
            tx_data_reg <= tx_data_next;
            burst_reg   <= burst_next;
            idle_reg    <= idle_next;
            wb_reg      <= wb_next;
            last_reg    <= last_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        grant_next   = grant_reg;
        tx_data_next = tx_data_reg;
        burst_next   = burst_reg;
        idle_next    = idle_reg;
        wb_next      = wb_reg;
        last_next    = last_reg;
        req_ready    = '0;
        tx_start     = 1'b0;

        unique case (state_reg)
            IDLE: begin
                grant_next = '0;
                if (|req_valid) begin
                    state_next = ARB;
                end
            end

            ARB: begin
                if (|rr_gnt) begin
                    grant_next = rr_gnt;
                    burst_next = '0;
                    idle_next  = '0;
                    state_next = LOAD;
                end else begin
                    state_next = IDLE;
                end
            end

            LOAD: begin
                if (owner_valid) begin
                    // Handshake and serializer start share the cycle so each accepted
                    // byte maps to exactly one tx_start.
                    if (tx_empty) begin
                        req_ready    = grant_reg;
                        tx_start     = 1'b1;
                        tx_data_next = req_data[owner_idx];
                        burst_next   = (burst_reg == 8'hFF) ? burst_reg : burst_reg + 8'd1;
                        idle_next    = '0;
                        wb_next      = 1'b0;
                        state_next   = WAIT_BUSY;
                    end
                end else if (idle_reg == IDLE_LAST) begin
                    grant_next = '0;
                    last_next  = owner_idx;
                    idle_next  = '0;
                    state_next = IDLE;
                end else begin
                    idle_next = idle_reg + IDLE_W'(1);
                end
            end

            WAIT_BUSY: begin
                // A serializer that never reports busy must not wedge the arbiter.
                if (!tx_empty || wb_reg) begin
                    state_next = WAIT_DONE;
                end else begin
                    wb_next = 1'b1;
                end
            end

            WAIT_DONE: begin
                if (tx_empty) begin
                    if (tx_data_reg == EOM_BYTE || burst_reg >= BURST_MAX) begin
                        grant_next = '0;
                        last_next  = owner_idx;
                        state_next = IDLE;
                    end else begin
                        state_next = LOAD;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign grant   = grant_reg;
    assign tx_data = tx_data_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: byte sources and a serializer are modelled here; every expected
// (requester, byte) is queued at stimulus time and popped on each tx_start.
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

    localparam int MAX_BURST = 4;
    localparam int IDLE_TO   = 20;
    localparam int FRAME     = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      req_valid = '0;
    logic [1:0][7:0] req_data = '0;
    logic [1:0]      req_ready;
    logic [1:0]      grant;
    logic [7:0]      tx_data;
    logic            tx_start;
    logic            tx_empty = 1'b1;

    typedef struct packed {
        logic       req;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int last_rise_cyc = 0;
    int start_prev = 0;
    int start_last = 0;
    int rdy_cnt = 0;
    int start_cnt = 0;
    int ser_cnt = 0;
    bit stuck = 1'b0;
    bit ser_arm = 1'b0;
    bit pend_chk = 1'b0;
    bit [1:0]   pend_pop = '0;
    logic [7:0] pend_data = '0;

    uart_tx_arbiter #(
        .MAX_BURST (MAX_BURST),
        .EOM_BYTE  (8'h0A),
        .IDLE_TO   (IDLE_TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .grant     (grant),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_empty  (tx_empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic src(input int r, input logic [7:0] b);
        if (r == 0) q0.push_back(b);
        else        q1.push_back(b);
    endtask

    task automatic expect_byte(input int r, input logic [7:0] b);
        exp_t e;
        e.req  = r[0];
        e.data = b;
        sb.push_back(e);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (!(sb.size() == 0 && q0.size() == 0 && q1.size() == 0 &&
                 grant == 2'b00 && tx_empty && !pend_chk)) begin
            @(negedge clk);
            #2;
            n++;
            if (n > budget) begin
                check({tag, "_timeout"}, 32'd0, 32'd1);
                break;
            end
        end
        repeat (2) @(negedge clk);
        #2;
    endtask

    // Source and serializer model: inputs change at the falling edge, outputs are
    // sampled 1 time unit later, and a handshake seen here completes on the next rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (pend_pop[0]) void'(q0.pop_front());
            if (pend_pop[1]) void'(q1.pop_front());
            pend_pop = '0;
            if (ser_arm) begin
                ser_arm = 1'b0;
                if (!stuck) begin
                    tx_empty = 1'b0;
                    ser_cnt  = FRAME;
                end
            end else if (ser_cnt > 0) begin
                ser_cnt--;
                if (ser_cnt == 0) begin
                    tx_empty      = 1'b1;
                    last_rise_cyc = cyc;
                end
            end
            req_valid[0] = (q0.size() > 0);
            req_data[0]  = (q0.size() > 0) ? q0[0] : 8'h00;
            req_valid[1] = (q1.size() > 0);
            req_data[1]  = (q1.size() > 0) ? q1[0] : 8'h00;
            #1;
            if (pend_chk) begin
                pend_chk = 1'b0;
                check("tx_data", tx_data, pend_data);
                $display("[TB] byte %02h from requester grant=%b", tx_data, grant);
            end
            if (|req_ready) begin
                rdy_cnt++;
                check("ready_owner", req_ready & ~grant, 2'b00);
            end
            for (int i = 0; i < 2; i++) begin
                if (req_ready[i] && req_valid[i]) pend_pop[i] = 1'b1;
            end
            if (tx_start) begin
                start_cnt++;
                start_prev = start_last;
                start_last = cyc;
                ser_arm    = 1'b1;
                check("empty_at_start", tx_empty, 1'b1);
                if (sb.size() == 0) begin
                    check("sb_nonempty", 32'd0, 32'd1);
                end else begin
                    e = sb.pop_front();
                    check("grant", grant, e.req ? 2'b10 : 2'b01);
                    pend_data = e.data;
                    pend_chk  = 1'b1;
                end
            end
        end
    end

    initial begin
        int base;
        int n;

        repeat (3) @(negedge clk);
        #2;
        check("rst_grant", grant, 2'b00);
        check("rst_ready", req_ready, 2'b00);
        check("rst_start", tx_start, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        rst = 1'b0;

        // Single requester, two-byte message.
        base = start_cnt;
        src(0, 8'h41); src(0, 8'h0A);
        expect_byte(0, 8'h41); expect_byte(0, 8'h0A);
        wait_idle("single", 200);
        check("single_starts", start_cnt - base, 2);
        check("single_grant_idle", grant, 2'b00);

        // Both valid from reset: requester 0 goes first, messages never interleave.
        rst = 1'b1;
        src(0, 8'h41); src(0, 8'h42); src(0, 8'h0A);
        src(1, 8'h43); src(1, 8'h0A);
        expect_byte(0, 8'h41); expect_byte(0, 8'h42); expect_byte(0, 8'h0A);
        expect_byte(1, 8'h43); expect_byte(1, 8'h0A);
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        base = start_cnt;
        wait_idle("contention", 300);
        check("contention_starts", start_cnt - base, 5);

        // Burst limit forces re-arbitration after MAX_BURST bytes.
        base = start_cnt;
        for (int i = 0; i < 10; i++) src(0, 8'(8'h10 + i));
        src(1, 8'h44); src(1, 8'h0A);
        for (int i = 0; i < 4; i++) expect_byte(0, 8'(8'h10 + i));
        expect_byte(1, 8'h44); expect_byte(1, 8'h0A);
        for (int i = 4; i < 10; i++) expect_byte(0, 8'(8'h10 + i));
        wait_idle("burst", 600);
        check("burst_starts", start_cnt - base, 12);

        // Idle timeout: the owner goes quiet after one byte.
        src(0, 8'h31);
        expect_byte(0, 8'h31);
        n = 0;
        while (grant != 2'b01 && n < 100) begin
            @(negedge clk);
            #2;
            n++;
        end
        check("to_granted", grant, 2'b01);
        src(1, 8'h45); src(1, 8'h0A);
        expect_byte(1, 8'h45); expect_byte(1, 8'h0A);
        n = 0;
        while (grant != 2'b00 && n < 200) begin
            @(negedge clk);
            #2;
            n++;
        end
        // The exit edge follows the rise sample, and the drop is seen one sample after its edge.
        check("to_release_cycles", cyc - last_rise_cyc, IDLE_TO + 1);
        wait_idle("timeout_next", 300);

        // Serializer that never reports busy.
        stuck = 1'b1;
        base = start_cnt;
        src(0, 8'h55); src(0, 8'h0A);
        expect_byte(0, 8'h55); expect_byte(0, 8'h0A);
        wait_idle("stuck", 200);
        check("stuck_starts", start_cnt - base, 2);
        check("stuck_interval", start_last - start_prev, 4);
        stuck = 1'b0;

        // Reset while a frame is still on the wire.
        base = start_cnt;
        src(0, 8'h66); src(0, 8'h77); src(0, 8'h0A);
        expect_byte(0, 8'h66); expect_byte(0, 8'h77); expect_byte(0, 8'h0A);
        n = 0;
        while (!(tx_data == 8'h66 && !tx_empty) && n < 100) begin
            @(negedge clk);
            #2;
            n++;
        end
        check("rstmid_reached", tx_data, 8'h66);
        @(negedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_grant", grant, 2'b00);
        check("async_tx_data", tx_data, 8'h00);
        check("async_ready", req_ready, 2'b00);
        check("async_start", tx_start, 1'b0);
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        #2;
        check("post_rst_start", tx_start, 1'b0);
        check("post_rst_grant", grant, 2'b00);
        wait_idle("rstmid", 300);
        check("rstmid_starts", start_cnt - base, 3);

        check("final_sb_empty", sb.size(), 0);
        check("ready_vs_start", rdy_cnt, start_cnt);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
